// File: rtl/sid_bus_target.sv
// SID chip-bus responder: synchronises the phi2-framed bus, holds the 25 write-only
// registers, and serves POTX/POTY, voice-3 OSC3 and a simplified ENV3 on reads.
module sid_bus_target #(
  parameter logic [7:0] POT_X = 8'h00,
  parameter logic [7:0] POT_Y = 8'h00
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic       sid_clk,
  input  logic       sid_cs,
  input  logic       sid_wr,
  input  logic [4:0] sid_a,
  input  logic [7:0] sid_d_in,
  output logic [7:0] sid_d_out,
  output logic       sid_d_oe,
  input  logic [4:0] dbg_a,
  output logic [7:0] dbg_q
);

  localparam int NUM_REGS = 25;
  localparam logic [4:0] LAST_REG = 5'h18;

  // two-flop synchronisers, index [1] is the *_s view
  logic [1:0]      clk_sy, cs_sy, wr_sy;
  logic [1:0][4:0] a_sy;
  logic [1:0][7:0] d_sy;
  logic            clk_d;

  logic            sid_clk_s, sid_cs_s, sid_wr_s;
  logic [4:0]      sid_a_s;
  logic [7:0]      sid_d_s;
  logic            phi_rise, phi_fall;

  logic            acc_v, acc_wr;
  logic [4:0]      acc_a;
  logic [7:0]      acc_d;

  logic [7:0]      regs [NUM_REGS];
  logic [7:0]      bus_latch;

  logic [23:0]     acc;
  logic [23:0]     acc_nxt;
  logic [22:0]     lfsr;

  logic [15:0]     freq;
  logic [11:0]     pw;
  logic [3:0]      wave;
  logic            test, gate;
  logic [7:0]      w_tri, w_saw, w_pulse, w_noise;
  logic [7:0]      osc3, env3, rd_mux;

  assign sid_clk_s = clk_sy[1];
  assign sid_cs_s  = cs_sy[1];
  assign sid_wr_s  = wr_sy[1];
  assign sid_a_s   = a_sy[1];
  assign sid_d_s   = d_sy[1];
  assign phi_rise  = sid_clk_s & ~clk_d;
  assign phi_fall  = ~sid_clk_s & clk_d;

  assign freq = {regs[5'h0F], regs[5'h0E]};
  assign pw   = {regs[5'h11][3:0], regs[5'h10]};
  assign wave = regs[5'h12][7:4];
  assign test = regs[5'h12][3];
  assign gate = regs[5'h12][0];

  assign acc_nxt = acc + {8'h00, freq};

  assign w_tri   = acc[23] ? ~acc[22:15] : acc[22:15];
  assign w_saw   = acc[23:16];
  assign w_pulse = (acc[23:12] >= pw) ? 8'hFF : 8'h00;
  assign w_noise = {lfsr[20], lfsr[18], lfsr[14], lfsr[11], lfsr[9], lfsr[5], lfsr[2], lfsr[0]};

  // combined waveforms AND together; nothing selected reads as silence
  always_comb begin
    osc3 = 8'hFF;
    if (wave[0]) osc3 = osc3 & w_tri;
    if (wave[1]) osc3 = osc3 & w_saw;
    if (wave[2]) osc3 = osc3 & w_pulse;
    if (wave[3]) osc3 = osc3 & w_noise;
    if (wave == 4'h0) osc3 = 8'h00;
  end

  assign env3 = gate ? {regs[5'h14][7:4], regs[5'h14][7:4]} : 8'h00;

  always_comb begin
    case (sid_a_s)
      5'h19:   rd_mux = POT_X;
      5'h1A:   rd_mux = POT_Y;
      5'h1B:   rd_mux = osc3;
      5'h1C:   rd_mux = env3;
      default: rd_mux = bus_latch;
    endcase
  end

  assign dbg_q = (dbg_a <= LAST_REG) ? regs[dbg_a] : 8'h00;

  always_ff @(posedge clk32) begin
    if (rst) begin
      clk_sy <= '0;
      cs_sy  <= '0;
      wr_sy  <= '0;
      a_sy   <= '0;
      d_sy   <= '0;
      clk_d  <= 1'b0;
    end else begin
      clk_sy <= {clk_sy[0], sid_clk};
      cs_sy  <= {cs_sy[0], sid_cs};
      wr_sy  <= {wr_sy[0], sid_wr};
      a_sy   <= {a_sy[0], sid_a};
      d_sy   <= {d_sy[0], sid_d_in};
      clk_d  <= sid_clk_s;
    end
  end

  // capture runs through phi2-high; the falling edge commits whatever was seen last
  always_ff @(posedge clk32) begin
    if (rst) begin
      acc_v     <= 1'b0;
      acc_wr    <= 1'b0;
      acc_a     <= '0;
      acc_d     <= '0;
      bus_latch <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (phi_fall) begin
      acc_v <= 1'b0;
      if (acc_v && acc_wr) begin
        if (acc_a <= LAST_REG) regs[acc_a] <= acc_d;
        bus_latch <= acc_d;
      end
    end else if (sid_clk_s && !sid_cs_s) begin
      acc_v  <= 1'b1;
      acc_wr <= !sid_wr_s;
      acc_a  <= sid_a_s;
      acc_d  <= sid_d_s;
    end
  end

  // voice-3 oscillator advances once per phi2 cycle
  always_ff @(posedge clk32) begin
    if (rst) begin
      acc  <= '0;
      lfsr <= '1;
    end else if (phi_rise) begin
      if (test) begin
        acc  <= '0;
        lfsr <= '1;
      end else begin
        acc <= acc_nxt;
        if (!acc[19] && acc_nxt[19]) lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      sid_d_oe  <= 1'b0;
      sid_d_out <= '0;
    end else begin
      sid_d_oe  <= !sid_cs_s && sid_wr_s;
      sid_d_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sid_bus_target.sv
// Bench for sid_bus_target: bridge-style bus cycles, a vector table, corner sequences
// and randomised traffic checked against a phi2-cycle-level reference model.
module tb_sid_bus_target;

  logic       clk32 = 1'b0;
  logic       rst = 1'b1;
  logic       sid_clk = 1'b0;
  logic       sid_cs = 1'b1;
  logic       sid_wr = 1'b1;
  logic [4:0] sid_a = '0;
  logic [7:0] sid_d_in = '0;
  logic [7:0] sid_d_out;
  logic       sid_d_oe;
  logic [4:0] dbg_a = '0;
  logic [7:0] dbg_q;

  int vectors = 0;
  int miscompares = 0;

  sid_bus_target #(.POT_X(8'h00), .POT_Y(8'h00)) dut (
    .clk32(clk32), .rst(rst), .sid_clk(sid_clk), .sid_cs(sid_cs), .sid_wr(sid_wr),
    .sid_a(sid_a), .sid_d_in(sid_d_in), .sid_d_out(sid_d_out), .sid_d_oe(sid_d_oe),
    .dbg_a(dbg_a), .dbg_q(dbg_q)
  );

  always #5 clk32 = ~clk32;

  // reference model: state advanced once per phi2 cycle
  logic [7:0]  m_regs [25];
  logic [7:0]  m_latch;
  logic [23:0] m_acc;
  logic [22:0] m_lfsr;

  task automatic m_reset();
    for (int i = 0; i < 25; i++) m_regs[i] = 8'h00;
    m_latch = 8'h00;
    m_acc   = 24'h0;
    m_lfsr  = 23'h7FFFFF;
  endtask

  task automatic m_rise();
    int unsigned f, s;
    if (m_regs[18][3]) begin
      m_acc  = 24'h0;
      m_lfsr = 23'h7FFFFF;
    end else begin
      f = m_regs[15] * 256 + m_regs[14];
      s = (int'(m_acc) + f) % (1 << 24);
      if (m_acc < 24'h080000 || (m_acc % (1 << 20)) < (1 << 19))
        if ((s / (1 << 19)) % 2 == 1 && ((m_acc / (1 << 19)) % 2 == 0))
          m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
      m_acc = s[23:0];
    end
  endtask

  task automatic m_write(input logic [4:0] a, input logic [7:0] d);
    if (a <= 5'h18) m_regs[a] = d;
    m_latch = d;
  endtask

  function automatic logic [7:0] m_osc3();
    int unsigned a, t, r;
    logic [7:0] o;
    logic [3:0] w;
    a = m_acc;
    w = m_regs[18][7:4];
    o = 8'hFF;
    if (w[0]) begin
      t = (a / (1 << 15)) % 256;
      if (a >= (1 << 23)) t = 255 - t;
      o = o & t[7:0];
    end
    if (w[1]) begin
      t = a / (1 << 16);
      o = o & t[7:0];
    end
    if (w[2]) begin
      r = (m_regs[17] % 16) * 256 + m_regs[16];
      o = o & (((a / (1 << 12)) >= r) ? 8'hFF : 8'h00);
    end
    if (w[3]) o = o & {m_lfsr[20], m_lfsr[18], m_lfsr[14], m_lfsr[11],
                       m_lfsr[9], m_lfsr[5], m_lfsr[2], m_lfsr[0]};
    if (w == 4'h0) o = 8'h00;
    return o;
  endfunction

  function automatic logic [7:0] m_read(input logic [4:0] a);
    case (a)
      5'h19:   return 8'h00;
      5'h1A:   return 8'h00;
      5'h1B:   return m_osc3();
      5'h1C:   return m_regs[18][0] ? {2{m_regs[20][7:4]}} : 8'h00;
      default: return m_latch;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic phi_high();
    sid_clk = 1'b0;
    tick(8);
    sid_clk = 1'b1;
    m_rise();
    tick(2);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    logic oe_seen;
    oe_seen = 1'b0;
    phi_high();
    sid_cs = 1'b0; sid_wr = 1'b0; sid_a = a; sid_d_in = d;
    for (int i = 0; i < 14; i++) begin tick(1); oe_seen |= sid_d_oe; end
    sid_clk = 1'b0;
    m_write(a, d);
    for (int i = 0; i < 6; i++) begin tick(1); oe_seen |= sid_d_oe; end
    sid_cs = 1'b1; sid_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(1); oe_seen |= sid_d_oe; end
    check("oe_during_write", {7'h0, oe_seen}, 8'h00);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [7:0] q);
    phi_high();
    sid_cs = 1'b0; sid_wr = 1'b1; sid_a = a;
    tick(14);
    check("oe_read", {7'h0, sid_d_oe}, 8'h01);
    q = sid_d_out;
    sid_clk = 1'b0;
    tick(2);
    sid_cs = 1'b1;
    tick(2);
    check("oe_hold_2", {7'h0, sid_d_oe}, 8'h01);
    tick(1);
    check("oe_drop_3", {7'h0, sid_d_oe}, 8'h00);
  endtask

  task automatic phi_idle(input int n);
    for (int i = 0; i < n; i++) begin
      phi_high();
      tick(6);
    end
  endtask

  typedef struct {
    int         op;   // 0 write, 1 read check, 2 debug-port check
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [14];
  logic [7:0] q;
  logic [4:0] ra;
  logic [7:0] rd;

  initial begin
    tbl[0]  = '{0, 5'h18, 8'h0F, 8'h00};
    tbl[1]  = '{2, 5'h18, 8'h00, 8'h0F};
    tbl[2]  = '{1, 5'h05, 8'h00, 8'h0F};
    tbl[3]  = '{0, 5'h14, 8'hA3, 8'h00};
    tbl[4]  = '{0, 5'h12, 8'h01, 8'h00};
    tbl[5]  = '{1, 5'h1C, 8'h00, 8'hAA};
    tbl[6]  = '{0, 5'h12, 8'h00, 8'h00};
    tbl[7]  = '{1, 5'h1C, 8'h00, 8'h00};
    tbl[8]  = '{1, 5'h19, 8'h00, 8'h00};
    tbl[9]  = '{1, 5'h1A, 8'h00, 8'h00};
    tbl[10] = '{0, 5'h1D, 8'h5A, 8'h00};
    tbl[11] = '{2, 5'h1D, 8'h00, 8'h00};
    tbl[12] = '{1, 5'h00, 8'h00, 8'h5A};
    tbl[13] = '{2, 5'h14, 8'h00, 8'hA3};

    m_reset();
    tick(4);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 25; i++) begin
      dbg_a = 5'(i);
      #1 check("reset_dbg", dbg_q, 8'h00);
    end
    check("idle_oe", {7'h0, sid_d_oe}, 8'h00);
    bus_read(5'h1B, q);
    check("reset_osc3", q, 8'h00);

    for (int i = 0; i < 14; i++) begin
      case (tbl[i].op)
        0: bus_write(tbl[i].a, tbl[i].d);
        1: begin bus_read(tbl[i].a, q); check("tbl_read", q, tbl[i].exp); end
        default: begin dbg_a = tbl[i].a; #1 check("tbl_dbg", dbg_q, tbl[i].exp); end
      endcase
    end

    // sawtooth from a known-zero accumulator
    bus_write(5'h0E, 8'h00);
    bus_write(5'h0F, 8'h01);
    bus_write(5'h12, 8'h20);
    phi_idle(256);
    bus_read(5'h1B, q);
    check("saw_256", q, 8'h01);
    check("saw_model", q, m_read(5'h1B));

    // TEST holds the oscillator, then pulse with zero width is always high
    bus_write(5'h12, 8'h08);
    phi_idle(4);
    bus_write(5'h10, 8'h00);
    bus_write(5'h11, 8'h00);
    bus_write(5'h12, 8'h40);
    bus_read(5'h1B, q);
    check("pulse_ff", q, 8'hFF);

    // reset while a read is being driven
    phi_high();
    sid_cs = 1'b0; sid_wr = 1'b1; sid_a = 5'h19;
    tick(6);
    check("pre_rst_oe", {7'h0, sid_d_oe}, 8'h01);
    rst = 1'b1;
    tick(1);
    check("rst_oe", {7'h0, sid_d_oe}, 8'h00);
    sid_cs = 1'b1;
    sid_clk = 1'b0;
    tick(3);
    rst = 1'b0;
    m_reset();
    tick(3);

    // reset in the middle of a write discards it
    phi_high();
    sid_cs = 1'b0; sid_wr = 1'b0; sid_a = 5'h03; sid_d_in = 8'h77;
    tick(8);
    rst = 1'b1;
    tick(1);
    sid_cs = 1'b1; sid_wr = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    sid_clk = 1'b0;
    tick(8);
    dbg_a = 5'h03;
    #1 check("rst_write_dropped", dbg_q, 8'h00);
    bus_read(5'h00, q);
    check("rst_latch", q, 8'h00);

    // randomised traffic against the model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          case ($urandom_range(0, 6))
            0: ra = 5'h0E;
            1: ra = 5'h0F;
            2: ra = 5'h10;
            3: ra = 5'h11;
            4: ra = 5'h12;
            5: ra = 5'h14;
            default: ra = 5'($urandom_range(0, 31));
          endcase
          rd = 8'($urandom_range(0, 255));
          if (ra == 5'h12 && $urandom_range(0, 3) != 0) rd[3] = 1'b0;
          bus_write(ra, rd);
        end
        2: begin
          ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(5'h1B, 5'h1C))
                                           : 5'($urandom_range(0, 31));
          bus_read(ra, q);
          check("rand_read", q, m_read(ra));
        end
        default: begin
          phi_idle($urandom_range(1, 20));
          ra = 5'($urandom_range(0, 31));
          dbg_a = ra;
          #1 check("rand_dbg", dbg_q, (ra <= 5'h18) ? m_regs[ra] : 8'h00);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
